// File: rtl/aes_const.sv
// Shared AES constants and helpers for the key expander and the cipher core.
//   Nb, MAX_NK, MAX_NR, SCHED_W : schedule geometry (60 words)
//   kexp_state_t                : expander FSM states
//   nk_of / nr_of               : key length code -> words / rounds (code 3 is treated as 128)
//   xtime                       : multiply by x in GF(2^8)
package aes_const;
    localparam int Nb      = 4;
    localparam int MAX_NK  = 8;
    localparam int MAX_NR  = 14;
    localparam int SCHED_W = Nb * (MAX_NR + 1);

    typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} kexp_state_t;

    function automatic logic [3:0] nk_of(input logic [1:0] kl);
        case (kl)
            2'd1:    return 4'd6;
            2'd2:    return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        case (kl)
            2'd1:    return 4'd12;
            2'd2:    return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction
endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box as a 256-entry case ROM.
//   a_i : input byte
//   s_o : substituted byte
module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);
    always_comb begin
        s_o = 8'h00;
        case (a_i)
            8'h00: s_o = 8'h63; 8'h01: s_o = 8'h7c; 8'h02: s_o = 8'h77; 8'h03: s_o = 8'h7b; 8'h04: s_o = 8'hf2; 8'h05: s_o = 8'h6b; 8'h06: s_o = 8'h6f; 8'h07: s_o = 8'hc5;
            8'h08: s_o = 8'h30; 8'h09: s_o = 8'h01; 8'h0a: s_o = 8'h67; 8'h0b: s_o = 8'h2b; 8'h0c: s_o = 8'hfe; 8'h0d: s_o = 8'hd7; 8'h0e: s_o = 8'hab; 8'h0f: s_o = 8'h76;
            8'h10: s_o = 8'hca; 8'h11: s_o = 8'h82; 8'h12: s_o = 8'hc9; 8'h13: s_o = 8'h7d; 8'h14: s_o = 8'hfa; 8'h15: s_o = 8'h59; 8'h16: s_o = 8'h47; 8'h17: s_o = 8'hf0;
            8'h18: s_o = 8'had; 8'h19: s_o = 8'hd4; 8'h1a: s_o = 8'ha2; 8'h1b: s_o = 8'haf; 8'h1c: s_o = 8'h9c; 8'h1d: s_o = 8'ha4; 8'h1e: s_o = 8'h72; 8'h1f: s_o = 8'hc0;
            8'h20: s_o = 8'hb7; 8'h21: s_o = 8'hfd; 8'h22: s_o = 8'h93; 8'h23: s_o = 8'h26; 8'h24: s_o = 8'h36; 8'h25: s_o = 8'h3f; 8'h26: s_o = 8'hf7; 8'h27: s_o = 8'hcc;
            8'h28: s_o = 8'h34; 8'h29: s_o = 8'ha5; 8'h2a: s_o = 8'he5; 8'h2b: s_o = 8'hf1; 8'h2c: s_o = 8'h71; 8'h2d: s_o = 8'hd8; 8'h2e: s_o = 8'h31; 8'h2f: s_o = 8'h15;
            8'h30: s_o = 8'h04; 8'h31: s_o = 8'hc7; 8'h32: s_o = 8'h23; 8'h33: s_o = 8'hc3; 8'h34: s_o = 8'h18; 8'h35: s_o = 8'h96; 8'h36: s_o = 8'h05; 8'h37: s_o = 8'h9a;
            8'h38: s_o = 8'h07; 8'h39: s_o = 8'h12; 8'h3a: s_o = 8'h80; 8'h3b: s_o = 8'he2; 8'h3c: s_o = 8'heb; 8'h3d: s_o = 8'h27; 8'h3e: s_o = 8'hb2; 8'h3f: s_o = 8'h75;
            8'h40: s_o = 8'h09; 8'h41: s_o = 8'h83; 8'h42: s_o = 8'h2c; 8'h43: s_o = 8'h1a; 8'h44: s_o = 8'h1b; 8'h45: s_o = 8'h6e; 8'h46: s_o = 8'h5a; 8'h47: s_o = 8'ha0;
            8'h48: s_o = 8'h52; 8'h49: s_o = 8'h3b; 8'h4a: s_o = 8'hd6; 8'h4b: s_o = 8'hb3; 8'h4c: s_o = 8'h29; 8'h4d: s_o = 8'he3; 8'h4e: s_o = 8'h2f; 8'h4f: s_o = 8'h84;
            8'h50: s_o = 8'h53; 8'h51: s_o = 8'hd1; 8'h52: s_o = 8'h00; 8'h53: s_o = 8'hed; 8'h54: s_o = 8'h20; 8'h55: s_o = 8'hfc; 8'h56: s_o = 8'hb1; 8'h57: s_o = 8'h5b;
            8'h58: s_o = 8'h6a; 8'h59: s_o = 8'hcb; 8'h5a: s_o = 8'hbe; 8'h5b: s_o = 8'h39; 8'h5c: s_o = 8'h4a; 8'h5d: s_o = 8'h4c; 8'h5e: s_o = 8'h58; 8'h5f: s_o = 8'hcf;
            8'h60: s_o = 8'hd0; 8'h61: s_o = 8'hef; 8'h62: s_o = 8'haa; 8'h63: s_o = 8'hfb; 8'h64: s_o = 8'h43; 8'h65: s_o = 8'h4d; 8'h66: s_o = 8'h33; 8'h67: s_o = 8'h85;
            8'h68: s_o = 8'h45; 8'h69: s_o = 8'hf9; 8'h6a: s_o = 8'h02; 8'h6b: s_o = 8'h7f; 8'h6c: s_o = 8'h50; 8'h6d: s_o = 8'h3c; 8'h6e: s_o = 8'h9f; 8'h6f: s_o = 8'ha8;
            8'h70: s_o = 8'h51; 8'h71: s_o = 8'ha3; 8'h72: s_o = 8'h40; 8'h73: s_o = 8'h8f; 8'h74: s_o = 8'h92; 8'h75: s_o = 8'h9d; 8'h76: s_o = 8'h38; 8'h77: s_o = 8'hf5;
            8'h78: s_o = 8'hbc; 8'h79: s_o = 8'hb6; 8'h7a: s_o = 8'hda; 8'h7b: s_o = 8'h21; 8'h7c: s_o = 8'h10; 8'h7d: s_o = 8'hff; 8'h7e: s_o = 8'hf3; 8'h7f: s_o = 8'hd2;
            8'h80: s_o = 8'hcd; 8'h81: s_o = 8'h0c; 8'h82: s_o = 8'h13; 8'h83: s_o = 8'hec; 8'h84: s_o = 8'h5f; 8'h85: s_o = 8'h97; 8'h86: s_o = 8'h44; 8'h87: s_o = 8'h17;
            8'h88: s_o = 8'hc4; 8'h89: s_o = 8'ha7; 8'h8a: s_o = 8'h7e; 8'h8b: s_o = 8'h3d; 8'h8c: s_o = 8'h64; 8'h8d: s_o = 8'h5d; 8'h8e: s_o = 8'h19; 8'h8f: s_o = 8'h73;
            8'h90: s_o = 8'h60; 8'h91: s_o = 8'h81; 8'h92: s_o = 8'h4f; 8'h93: s_o = 8'hdc; 8'h94: s_o = 8'h22; 8'h95: s_o = 8'h2a; 8'h96: s_o = 8'h90; 8'h97: s_o = 8'h88;
            8'h98: s_o = 8'h46; 8'h99: s_o = 8'hee; 8'h9a: s_o = 8'hb8; 8'h9b: s_o = 8'h14; 8'h9c: s_o = 8'hde; 8'h9d: s_o = 8'h5e; 8'h9e: s_o = 8'h0b; 8'h9f: s_o = 8'hdb;
            8'ha0: s_o = 8'he0; 8'ha1: s_o = 8'h32; 8'ha2: s_o = 8'h3a; 8'ha3: s_o = 8'h0a; 8'ha4: s_o = 8'h49; 8'ha5: s_o = 8'h06; 8'ha6: s_o = 8'h24; 8'ha7: s_o = 8'h5c;
            8'ha8: s_o = 8'hc2; 8'ha9: s_o = 8'hd3; 8'haa: s_o = 8'hac; 8'hab: s_o = 8'h62; 8'hac: s_o = 8'h91; 8'had: s_o = 8'h95; 8'hae: s_o = 8'he4; 8'haf: s_o = 8'h79;
            8'hb0: s_o = 8'he7; 8'hb1: s_o = 8'hc8; 8'hb2: s_o = 8'h37; 8'hb3: s_o = 8'h6d; 8'hb4: s_o = 8'h8d; 8'hb5: s_o = 8'hd5; 8'hb6: s_o = 8'h4e; 8'hb7: s_o = 8'ha9;
            8'hb8: s_o = 8'h6c; 8'hb9: s_o = 8'h56; 8'hba: s_o = 8'hf4; 8'hbb: s_o = 8'hea; 8'hbc: s_o = 8'h65; 8'hbd: s_o = 8'h7a; 8'hbe: s_o = 8'hae; 8'hbf: s_o = 8'h08;
            8'hc0: s_o = 8'hba; 8'hc1: s_o = 8'h78; 8'hc2: s_o = 8'h25; 8'hc3: s_o = 8'h2e; 8'hc4: s_o = 8'h1c; 8'hc5: s_o = 8'ha6; 8'hc6: s_o = 8'hb4; 8'hc7: s_o = 8'hc6;
            8'hc8: s_o = 8'he8; 8'hc9: s_o = 8'hdd; 8'hca: s_o = 8'h74; 8'hcb: s_o = 8'h1f; 8'hcc: s_o = 8'h4b; 8'hcd: s_o = 8'hbd; 8'hce: s_o = 8'h8b; 8'hcf: s_o = 8'h8a;
            8'hd0: s_o = 8'h70; 8'hd1: s_o = 8'h3e; 8'hd2: s_o = 8'hb5; 8'hd3: s_o = 8'h66; 8'hd4: s_o = 8'h48; 8'hd5: s_o = 8'h03; 8'hd6: s_o = 8'hf6; 8'hd7: s_o = 8'h0e;
            8'hd8: s_o = 8'h61; 8'hd9: s_o = 8'h35; 8'hda: s_o = 8'h57; 8'hdb: s_o = 8'hb9; 8'hdc: s_o = 8'h86; 8'hdd: s_o = 8'hc1; 8'hde: s_o = 8'h1d; 8'hdf: s_o = 8'h9e;
            8'he0: s_o = 8'he1; 8'he1: s_o = 8'hf8; 8'he2: s_o = 8'h98; 8'he3: s_o = 8'h11; 8'he4: s_o = 8'h69; 8'he5: s_o = 8'hd9; 8'he6: s_o = 8'h8e; 8'he7: s_o = 8'h94;
            8'he8: s_o = 8'h9b; 8'he9: s_o = 8'h1e; 8'hea: s_o = 8'h87; 8'heb: s_o = 8'he9; 8'hec: s_o = 8'hce; 8'hed: s_o = 8'h55; 8'hee: s_o = 8'h28; 8'hef: s_o = 8'hdf;
            8'hf0: s_o = 8'h8c; 8'hf1: s_o = 8'ha1; 8'hf2: s_o = 8'h89; 8'hf3: s_o = 8'h0d; 8'hf4: s_o = 8'hbf; 8'hf5: s_o = 8'he6; 8'hf6: s_o = 8'h42; 8'hf7: s_o = 8'h68;
            8'hf8: s_o = 8'h41; 8'hf9: s_o = 8'h99; 8'hfa: s_o = 8'h2d; 8'hfb: s_o = 8'h0f; 8'hfc: s_o = 8'hb0; 8'hfd: s_o = 8'h54; 8'hfe: s_o = 8'hbb; 8'hff: s_o = 8'h16;
        endcase
    end
endmodule

// File: rtl/aes_kexp_seq.sv
// Sequential AES key expander (128/192/256 chosen per Start), one schedule word per cycle
// into a 60x32 register schedule, with a random-access 128-bit round-key read port.
//   clock, reset        : clock, async active-high reset
//   Start, KeyLen, Key  : request (accepted in IDLE/DONE), length code, key (word 0 in [255:224])
//   Busy, Done, Ready   : expansion in progress, completion pulse, schedule valid
//   Nr                  : round count of the current schedule
//   RdRound, RdKey      : round-key read port (0 when not Ready or RdRound > Nr)
//   Dec                 : only with AES_KEXP_INV_EN; reverses round order on the read port
module aes_kexp_seq
    import aes_const::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         Start,
    input  logic [1:0]   KeyLen,
    input  logic [255:0] Key,
`ifdef AES_KEXP_INV_EN
    input  logic         Dec,
`endif
    input  logic [3:0]   RdRound,
    output logic         Busy,
    output logic         Done,
    output logic         Ready,
    output logic [3:0]   Nr,
    output logic [127:0] RdKey
);
    kexp_state_t state_q, state_d;
    logic [31:0] w_q [SCHED_W];
    logic [5:0]  i_q;
    logic [2:0]  j_q;
    logic [7:0]  rcon_q;
    logic [3:0]  nk_q, nr_q;
    logic [1:0]  kl_q;
    logic        done_q, ready_q;
    logic        accept, load, step, last;
    logic [5:0]  last_idx;

    assign last_idx = 6'(Nb * (int'(nr_q) + 1) - 1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE, DONE: if (Start) begin
                accept  = 1'b1;
                state_d = LOAD;
            end
            LOAD: begin
                load    = 1'b1;
                state_d = EXPAND;
            end
            EXPAND: begin
                step = 1'b1;
                if (i_q == last_idx) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // SubWord path: RotWord only on the first word of each key-length group.
    logic [31:0] t_prev, sb_in, sb_out, t_new;
    assign t_prev = w_q[i_q - 6'd1];
    assign sb_in  = (j_q == 3'd0) ? {t_prev[23:0], t_prev[31:24]} : t_prev;

    for (genvar b = 0; b < 4; b++) begin : g_sub
        aes_sbox u_sbox (.a_i(sb_in[8*b +: 8]), .s_o(sb_out[8*b +: 8]));
    end

    always_comb begin
        t_new = t_prev;
        if (j_q == 3'd0)                         t_new = sb_out ^ {rcon_q, 24'h0};
        else if (nk_q == 4'd8 && j_q == 3'd4)    t_new = sb_out;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            i_q     <= '0;
            j_q     <= '0;
            rcon_q  <= '0;
            nk_q    <= '0;
            nr_q    <= '0;
            kl_q    <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            done_q <= last;
            if (accept) begin
                kl_q    <= KeyLen;
                ready_q <= 1'b0;
            end
            if (last) ready_q <= 1'b1;
            if (load) begin
                nk_q   <= nk_of(kl_q);
                nr_q   <= nr_of(kl_q);
                i_q    <= 6'(nk_of(kl_q));
                j_q    <= '0;
                rcon_q <= 8'h01;
            end
            if (step) begin
                i_q <= i_q + 6'd1;
                j_q <= ({1'b0, j_q} == nk_q - 4'd1) ? 3'd0 : j_q + 3'd1;
                if (j_q == 3'd0) rcon_q <= xtime(rcon_q);
            end
        end
    end

    // Key words are captured straight into the schedule when Start is accepted, so no
    // separate key register is needed. All eight slots are written; for shorter keys the
    // surplus slots are overwritten by expansion before they are ever read.
    always_ff @(posedge clock) begin
        if (accept)
            for (int k = 0; k < MAX_NK; k++) w_q[k] <= Key[255 - 32*k -: 32];
        if (step)
            w_q[i_q] <= w_q[i_q - 6'(nk_q)] ^ t_new;
    end

    logic [3:0] rd_sel;
    logic [5:0] rd_base;
`ifdef AES_KEXP_INV_EN
    assign rd_sel = Dec ? nr_q - RdRound : RdRound;
`else
    assign rd_sel = RdRound;
`endif
    assign rd_base = {rd_sel, 2'b00};

    always_comb begin
        RdKey = '0;
        if (ready_q && RdRound <= nr_q)
            RdKey = {w_q[rd_base], w_q[rd_base + 6'd1], w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]};
    end

    assign Busy  = (state_q == LOAD) || (state_q == EXPAND);
    assign Done  = done_q;
    assign Ready = ready_q;
    assign Nr    = nr_q;
endmodule

// File: tb/tb_aes_kexp_seq.sv
module tb_aes_kexp_seq;
    logic         clock = 1'b0;
    logic         reset;
    logic         Start;
    logic [1:0]   KeyLen;
    logic [255:0] Key;
`ifdef AES_KEXP_INV_EN
    logic         Dec;
`endif
    logic [3:0]   RdRound;
    logic         Busy, Done, Ready;
    logic [3:0]   Nr;
    logic [127:0] RdKey;

    int checks = 0;
    int errors = 0;

    aes_kexp_seq dut (
        .clock(clock), .reset(reset), .Start(Start), .KeyLen(KeyLen), .Key(Key),
`ifdef AES_KEXP_INV_EN
        .Dec(Dec),
`endif
        .RdRound(RdRound), .Busy(Busy), .Done(Done), .Ready(Ready), .Nr(Nr), .RdKey(RdKey)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    logic [7:0]  sb [256];
    logic [31:0] wm [60];
    int          mnk, mnr;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] v);
        return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
    endfunction

    task automatic model_expand(input logic [1:0] kl, input logic [255:0] key);
        logic [31:0] t;
        logic [7:0]  rc;
        mnk = (kl == 2'd1) ? 6 : (kl == 2'd2) ? 8 : 4;
        mnr = mnk + 6;
        for (int i = 0; i < mnk; i++) wm[i] = key[255 - 32*i -: 32];
        for (int i = mnk; i < 4 * (mnr + 1); i++) begin
            t = wm[i-1];
            if (i % mnk == 0) begin
                rc = 8'h01;
                for (int n = 1; n < i / mnk; n++) rc = gmul(rc, 8'h02);
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            end else if (mnk > 6 && i % mnk == 4) begin
                t = subw(t);
            end
            wm[i] = wm[i-mnk] ^ t;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, expv);
        end
    endtask

    // Issue Start, scramble the key inputs afterwards, and count cycles until Done.
    // restart_at >= 0 pulses a second Start that many cycles into the run.
    task automatic run_key(input logic [1:0] kl, input logic [255:0] key,
                           input int restart_at, output int lat);
        @(negedge clock);
        Start = 1'b1; KeyLen = kl; Key = key;
        @(negedge clock);
        Start = 1'b0; KeyLen = kl ^ 2'b01; Key = ~key; RdRound = 4'd0;
        #1;
        chk("busy_after_start", Busy, 1);
        chk("ready_drop", Ready, 0);
        chk("read_while_busy", RdKey, 0);
        lat = 0;
        while (!Done && lat < 200) begin
            Start = (lat == restart_at);
            @(negedge clock);
            lat++;
        end
        Start = 1'b0;
        @(negedge clock);
        chk("done_pulse_end", Done, 0);
        chk("ready_held", Ready, 1);
        chk("busy_end", Busy, 0);
    endtask

    task automatic cmp_model(input logic [1:0] kl, input logic [255:0] key);
        logic [127:0] expv;
        model_expand(kl, key);
        for (int r = 0; r < 16; r++) begin
            @(negedge clock);
            RdRound = 4'(r);
            #1;
            expv = (r > mnr) ? 128'h0 : {wm[4*r], wm[4*r+1], wm[4*r+2], wm[4*r+3]};
            chk($sformatf("model_round%0d", r), RdKey, expv);
        end
    endtask

    typedef struct {
        logic [1:0]   kl;
        logic [255:0] key;
        int           lat;
        int           nr;
        int           rd;
        logic [127:0] rk;
    } vec_t;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    initial begin
        vec_t vec [5];
        int   lat;
        logic [1:0]   kl;
        logic [255:0] key;

        vec[0] = '{2'd0, K128, 41, 10, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vec[1] = '{2'd1, K192, 47, 12, 12, 128'he98ba06f448c773c8ecc720401002202};
        vec[2] = '{2'd2, K256, 53, 14, 14, 128'hfe4890d1e6188d0b046df344706c631e};
        vec[3] = '{2'd2, K256, 53, 14,  0, 128'h603deb1015ca71be2b73aef0857d7781};
        // reserved length code, junk in the unused key bits must be ignored
        vec[4] = '{2'd3, {K128[255:128], 128'hdeadbeef_0badf00d_12345678_9abcdef0}, 41, 10, 10,
                   128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

        reset = 1'b1; Start = 1'b0; KeyLen = 2'd0; Key = '0; RdRound = 4'd0;
`ifdef AES_KEXP_INV_EN
        Dec = 1'b0;
`endif
        build_sbox();
        repeat (2) @(negedge clock);
        chk("reset_busy", Busy, 0);
        chk("reset_done", Done, 0);
        chk("reset_ready", Ready, 0);
        chk("reset_nr", Nr, 0);
        chk("reset_rdkey", RdKey, 0);
        reset = 1'b0;

        // known-answer vectors
        for (int v = 0; v < 5; v++) begin
            run_key(vec[v].kl, vec[v].key, -1, lat);
            chk($sformatf("vec%0d_latency", v), lat, vec[v].lat);
            chk($sformatf("vec%0d_nr", v), Nr, vec[v].nr);
            RdRound = 4'(vec[v].rd);
            #1;
            chk($sformatf("vec%0d_rdkey", v), RdKey, vec[v].rk);
            cmp_model(vec[v].kl, vec[v].key);
        end

        // second Start during expansion is ignored
        run_key(2'd2, K256, 20, lat);
        chk("restart_latency", lat, 53);
        @(negedge clock); RdRound = 4'd14; #1;
        chk("restart_round14", RdKey, 128'hfe4890d1e6188d0b046df344706c631e);
        @(negedge clock); RdRound = 4'd15; #1;
        chk("round15_zero", RdKey, 0);

        // reset in the middle of an AES-128 expansion
        @(negedge clock);
        Start = 1'b1; KeyLen = 2'd0; Key = K128;
        @(negedge clock);
        Start = 1'b0;
        repeat (29) @(negedge clock);
        reset = 1'b1; RdRound = 4'd10;
        #1;
        chk("abort_busy", Busy, 0);
        chk("abort_ready", Ready, 0);
        chk("abort_done", Done, 0);
        chk("abort_nr", Nr, 0);
        chk("abort_rdkey", RdKey, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("abort_ready_stays", Ready, 0);
        run_key(2'd0, K128, -1, lat);
        chk("after_abort_latency", lat, 41);
        RdRound = 4'd10; #1;
        chk("after_abort_round10", RdKey, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

`ifdef AES_KEXP_INV_EN
        @(negedge clock); Dec = 1'b1; RdRound = 4'd0; #1;
        chk("dec_round0", RdKey, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        @(negedge clock); RdRound = 4'd10; #1;
        chk("dec_round10", RdKey, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        @(negedge clock); Dec = 1'b0;
`endif

        // random keys and lengths against the model
        for (int it = 0; it < 8; it++) begin
            kl = 2'($urandom_range(0, 3));
            for (int k = 0; k < 8; k++) key[32*k +: 32] = $urandom();
            run_key(kl, key, -1, lat);
            model_expand(kl, key);
            chk($sformatf("rand%0d_latency", it), lat, 1 + 4 * (mnr + 1) - mnk);
            chk($sformatf("rand%0d_nr", it), Nr, mnr);
            cmp_model(kl, key);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
